clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run-time controller for the team's 50 %-duty even-ratio clock divider.
- Adds enable/stop sequencing: output always starts and stops low, with no truncated high phase.
- Adds a valid/ready configuration port; ratio changes are applied only at a period boundary, giving glitch-free output.
- Sits between the register/config interface and any downstream logic clocked or strobed by the divided clock.

Parameters:
- P_CNT_W, 16: width of the ratio and of the internal half-period counter.
- P_DEFAULT_DIV, 2: ratio active after reset. Must be even and >= P_MIN_DIV.
- P_MIN_DIV, 2: smallest legal ratio. Must be even and >= 2.

Ports:
- i_clk  in  1  system clock. Single clock domain.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  level request to run the divided clock.
- i_cfg_valid  in  1  a new ratio is offered on i_cfg_div.
- i_cfg_div  in  P_CNT_W  requested ratio N; output period = N i_clk cycles.
- o_cfg_ready  out  1  controller can accept a new ratio.
- o_cfg_err  out  1  one-cycle pulse: last accepted ratio was illegal and was dropped.
- o_clk_div  out  1  divided clock, registered.
- o_active  out  1  controller is in RUN or STOPPING.
- o_div_cur  out  P_CNT_W  ratio currently in effect.

Behaviour:
- Reset values, all asynchronous on i_rst:
  - state=IDLE, counter=0, o_clk_div=0, o_active=0, o_cfg_err=0, o_cfg_ready=1.
  - o_div_cur=P_DEFAULT_DIV; pending ratio discarded.
- Half-period H = o_div_cur >> 1.
  - Counter runs 0..H-1 in RUN and STOPPING.
  - At counter==H-1: o_clk_div toggles and counter clears to 0.
- State IDLE:
  - o_clk_div=0, counter held at 0.
  - If i_en=1: go to RUN next cycle. First rising edge of o_clk_div occurs H cycles after entering RUN.
- State RUN: divides continuously.
  - If i_en=0 while o_clk_div=0: go to IDLE next cycle and clear the counter; output stays low, so no glitch.
  - If i_en=0 while o_clk_div=1: go to STOPPING.
- State STOPPING:
  - Keeps counting until the high-to-low toggle, then goes to IDLE in that same edge.
  - If i_en returns to 1: go to RUN, counter undisturbed.
- o_active = (state != IDLE).
- Config handshake:
  - Transfer occurs when i_cfg_valid & o_cfg_ready.
  - Legal value (even and >= P_MIN_DIV): latched as pending; o_cfg_ready drops next cycle.
  - Illegal value (odd, or < P_MIN_DIV): dropped; o_cfg_err=1 for exactly the next cycle; o_cfg_ready stays 1.
- Applying a pending ratio:
  - In IDLE: applied on the cycle after the transfer.
  - In RUN or STOPPING: applied only on the cycle where o_clk_div toggles 1->0. The new H governs the following low half.
  - On apply, o_div_cur updates and o_cfg_ready returns to 1 in the same edge.
- Simultaneous events:
  - Transfer in the same cycle as a 1->0 boundary: not applied at that boundary; waits for the next one.
  - i_en falling in the same cycle a pending ratio is applied: both take effect.
- Reset mid-operation: output forced low immediately; any pending ratio is lost.

Optional Feature:
- Macro: CLK_DIV_CTRL_STROBE_EN.
- Defined:
  - Adds ports o_rise (out, 1) and o_fall (out, 1), both registered, reset 0.
  - o_rise pulses high for exactly the one cycle where o_clk_div becomes 1; o_fall likewise for 0.
  - Downstream logic can use these as i_clk-domain enables instead of the divided clock.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package clk_div_pkg holds:
  - state enum (IDLE, RUN, STOPPING);
  - localparam CLK_DIV_CNT_W=16;
  - function is_legal_div(N, min) for ratio checking.
- One natural sub-module: clk_div_core.
  - Contents: counter plus toggle flop, taking H as an input.
  - Outputs: a boundary flag (counter==H-1 and o_clk_div==1) to the controller FSM.

Test Plan:
- Reset with default 2, i_en=1: o_clk_div toggles every cycle; first high 1 cycle after RUN entry; o_active=1.
- Running at N=4, send cfg 8 mid-high-phase: o_cfg_ready=0 until the next 1->0 edge; o_div_cur=8 from that edge; next low and high phases are 4 cycles each.
- Send cfg 7, then cfg 0: o_cfg_err pulses 1 cycle each time; o_div_cur unchanged; o_cfg_ready never drops.
- N=6, drop i_en 1 cycle into the high phase: o_clk_div stays high 2 more cycles, falls, state=IDLE, o_active=0. Repeat with i_en dropped in the low phase: immediate IDLE, output stays 0.
- In STOPPING at N=10, re-assert i_en: no extra or short phase; period stays 10.
- Assert i_rst mid-high-phase with a ratio pending: o_clk_div=0 asynchronously; after release, o_div_cur=2 and o_cfg_ready=1.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock divider controller: controller
// state encoding, default counter width and the ratio legality check.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  // A ratio is usable when it gives a 50 % duty cycle (even) and is not
  // below the smallest ratio the divider is built for.
  function automatic logic is_legal_div(input int unsigned n, input int unsigned min_div);
    return (n[0] == 1'b0) && (n >= min_div);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and output toggle flop of the even-ratio divider.
// The controller supplies the half period H and a count enable; the core
// reports the high-to-low boundary so the controller can sequence stops
// and ratio changes. Optional macro CLK_DIV_CTRL_STROBE_EN adds registered
// rise/fall strobes aligned with the output edges.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int P_CNT_W = CLK_DIV_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cnt_en,
  input  logic [P_CNT_W-1:0] i_half,
  output logic               o_clk_div,
  output logic               o_boundary
`ifdef CLK_DIV_CTRL_STROBE_EN
  ,
  output logic               o_rise,
  output logic               o_fall
`endif
);

  logic [P_CNT_W-1:0] cnt;
  logic               toggle;

  assign toggle     = i_cnt_en && (cnt == (i_half - 1'b1));
  assign o_boundary = toggle && o_clk_div;

  // Count through one half period, flip the output at its last cycle; a
  // disabled core parks low with the counter cleared.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= '0;
      o_clk_div <= 1'b0;
    end else if (!i_cnt_en) begin
      cnt       <= '0;
      o_clk_div <= 1'b0;
    end else if (toggle) begin
      cnt       <= '0;
      o_clk_div <= ~o_clk_div;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef CLK_DIV_CTRL_STROBE_EN
  // One-cycle strobes registered on the same edge that changes o_clk_div.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= toggle && !o_clk_div;
      o_fall <= o_boundary;
    end
  end
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the 50 %-duty even-ratio clock divider.
// Sequences enable/stop so the output always starts and stops low with no
// truncated high phase, and accepts new ratios over a valid/ready port,
// applying them only at a high-to-low boundary (or at once when idle).
// Optional macro CLK_DIV_CTRL_STROBE_EN adds o_rise/o_fall enable strobes.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int P_CNT_W       = CLK_DIV_CNT_W,
  parameter int P_DEFAULT_DIV = 2,
  parameter int P_MIN_DIV     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_cfg_valid,
  input  logic [P_CNT_W-1:0] i_cfg_div,
  output logic               o_cfg_ready,
  output logic               o_cfg_err,
  output logic               o_clk_div,
  output logic               o_active,
  output logic [P_CNT_W-1:0] o_div_cur
`ifdef CLK_DIV_CTRL_STROBE_EN
  ,
  output logic               o_rise,
  output logic               o_fall
`endif
);

  state_e             state;
  logic               boundary;
  logic               cnt_en;
  logic               xfer;
  logic               cfg_legal;
  logic               apply;
  logic               pend_vld;
  logic [P_CNT_W-1:0] pend_div;
  logic [P_CNT_W-1:0] half;

  assign half      = o_div_cur >> 1;
  assign xfer      = i_cfg_valid && o_cfg_ready;
  assign cfg_legal = is_legal_div(32'(i_cfg_div), P_MIN_DIV);
  assign apply     = pend_vld && ((state == IDLE) || boundary);

  // Counting stops only when RUN loses its enable during the low half;
  // a high half is always completed.
  assign cnt_en = ((state == RUN) && (i_en || o_clk_div)) || (state == STOPPING);

  clk_div_core #(
    .P_CNT_W (P_CNT_W)
  ) u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cnt_en   (cnt_en),
    .i_half     (half),
    .o_clk_div  (o_clk_div),
    .o_boundary (boundary)
`ifdef CLK_DIV_CTRL_STROBE_EN
    ,
    .o_rise     (o_rise),
    .o_fall     (o_fall)
`endif
  );

  // Enable/stop sequencing with o_active registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      o_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_en) begin
            state    <= RUN;
            o_active <= 1'b1;
          end
        end
        RUN: begin
          if (!i_en) begin
            // A fall happening on this very edge already ends the high half.
            if (!o_clk_div || boundary) begin
              state    <= IDLE;
              o_active <= 1'b0;
            end else begin
              state <= STOPPING;
            end
          end
        end
        STOPPING: begin
          if (i_en) begin
            state <= RUN;
          end else if (boundary) begin
            state    <= IDLE;
            o_active <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          o_active <= 1'b0;
        end
      endcase
    end
  end

  // Config handshake: accept or reject an offer, apply a pending ratio at
  // the next safe point and reopen the port in the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cfg_ready <= 1'b1;
      o_cfg_err   <= 1'b0;
      pend_vld    <= 1'b0;
      o_div_cur   <= P_CNT_W'(P_DEFAULT_DIV);
    end else begin
      o_cfg_err <= xfer && !cfg_legal;
      if (apply) begin
        o_div_cur   <= pend_div;
        pend_vld    <= 1'b0;
        o_cfg_ready <= 1'b1;
      end else if (xfer && cfg_legal) begin
        pend_vld    <= 1'b1;
        o_cfg_ready <= 1'b0;
      end
    end
  end

  // Pending ratio payload, captured on a legal transfer.
  // NOTE: only the valid flag needs a reset; the payload is never read
  // while pend_vld is low, so it is left as a plain data register.
  always_ff @(posedge i_clk) begin
    if (xfer && cfg_legal) begin
      pend_div <= i_cfg_div;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl. A behavioural model tracks each
// period as a position 0..N-1 (low for the first N/2 cycles, high for the
// rest) plus a pending-ratio slot, and every cycle the DUT outputs are
// compared against it. Directed scenarios also check phase lengths and
// handshake timing against hand-derived constants.
module tb_clk_div_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_cfg_valid;
  logic [15:0] i_cfg_div;
  logic        o_cfg_ready;
  logic        o_cfg_err;
  logic        o_clk_div;
  logic        o_active;
  logic [15:0] o_div_cur;
`ifdef CLK_DIV_CTRL_STROBE_EN
  logic        o_rise;
  logic        o_fall;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(
    .P_CNT_W       (16),
    .P_DEFAULT_DIV (2),
    .P_MIN_DIV     (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_div   (i_cfg_div),
    .o_cfg_ready (o_cfg_ready),
    .o_cfg_err   (o_cfg_err),
    .o_clk_div   (o_clk_div),
    .o_active    (o_active),
    .o_div_cur   (o_div_cur)
`ifdef CLK_DIV_CTRL_STROBE_EN
    ,
    .o_rise      (o_rise),
    .o_fall      (o_fall)
`endif
  );

  always #5 i_clk = ~i_clk;

  // ---------------- behavioural reference model ----------------
  int unsigned m_n;
  int unsigned m_pos;
  int unsigned m_pend;
  bit          m_active;
  bit          m_pend_vld;
  bit          m_ready;
  bit          m_err;
  bit          m_rise;
  bit          m_fall;

  function automatic bit m_out();
    return m_active && (m_pos >= m_n / 2);
  endfunction

  task automatic model_reset();
    m_n = 2; m_pos = 0; m_pend = 0; m_active = 0; m_pend_vld = 0;
    m_ready = 1; m_err = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic model_step(input bit en, input bit valid, input logic [15:0] div);
    bit old_out, fall, xfer, legal, apply, new_out;
    old_out = m_out();
    fall    = m_active && (m_pos == m_n - 1);
    xfer    = valid && m_ready;
    legal   = (div[0] == 1'b0) && (div >= 16'd2);
    apply   = m_pend_vld && (!m_active || fall);
    if (!m_active) begin
      if (en) begin m_active = 1; m_pos = 0; end
    end else if (!en && !old_out) begin
      m_active = 0; m_pos = 0;
    end else if (fall) begin
      m_pos = 0;
      if (!en) m_active = 0;
    end else begin
      m_pos++;
    end
    if (apply) begin m_n = m_pend; m_pend_vld = 0; m_ready = 1; end
    m_err = xfer && !legal;
    if (xfer && legal) begin m_pend = div; m_pend_vld = 1; m_ready = 0; end
    new_out = m_out();
    m_rise  = new_out && !old_out;
    m_fall  = !new_out && old_out;
  endtask

  function automatic logic [21:0] mdl_exp();
`ifdef CLK_DIV_CTRL_STROBE_EN
    return {m_rise, m_fall, m_out(), m_active, m_ready, m_err, 16'(m_n)};
`else
    return {2'b00, m_out(), m_active, m_ready, m_err, 16'(m_n)};
`endif
  endfunction

  function automatic logic [21:0] dut_obs();
`ifdef CLK_DIV_CTRL_STROBE_EN
    return {o_rise, o_fall, o_clk_div, o_active, o_cfg_ready, o_cfg_err, o_div_cur};
`else
    return {2'b00, o_clk_div, o_active, o_cfg_ready, o_cfg_err, o_div_cur};
`endif
  endfunction

  // Advance one clock: inputs are sampled as the DUT sees them, the model
  // steps, and outputs settle 1 time unit after the edge.
  task automatic tick();
    bit          e, v;
    logic [15:0] d;
    e = i_en; v = i_cfg_valid; d = i_cfg_div;
    @(posedge i_clk);
    model_step(e, v, d);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1; i_en = 0; i_cfg_valid = 0; i_cfg_div = '0;
    repeat (3) @(posedge i_clk);
    #1;
    model_reset();
    checks++;
    if ({o_clk_div, o_active, o_cfg_ready, o_cfg_err} !== 4'b0010) begin
      errors++; $display("FAIL reset_flags: got %b expected 0010", {o_clk_div, o_active, o_cfg_ready, o_cfg_err});
    end
    checks++;
    if (o_div_cur !== 16'd2) begin
      errors++; $display("FAIL reset_div: got %0d expected 2", o_div_cur);
    end
    #3 i_rst = 0;
    tick();
    checks++;
    if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL reset_release: got %h expected %h", dut_obs(), mdl_exp()); end
  endtask

  task automatic test_default_ratio();
    logic prev;
    i_en = 1;
    tick();
    checks++;
    if (o_active !== 1'b1 || o_clk_div !== 1'b0) begin
      errors++; $display("FAIL run_entry: active %b clk %b expected 1 0", o_active, o_clk_div);
    end
    tick();
    checks++;
    if (o_clk_div !== 1'b1) begin errors++; $display("FAIL first_high_n2: got %b expected 1", o_clk_div); end
    prev = o_clk_div;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (o_clk_div === prev) begin errors++; $display("FAIL toggle_n2: clk %b did not toggle", o_clk_div); end
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL run_n2: got %h expected %h", dut_obs(), mdl_exp()); end
      prev = o_clk_div;
    end
    i_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL stop_n2: got %h expected %h", dut_obs(), mdl_exp()); end
    end
  endtask

  task automatic test_ratio_change();
    int n;
    i_cfg_valid = 1; i_cfg_div = 16'd4;
    tick();
    i_cfg_valid = 0;
    checks++;
    if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg4_ready_drop: got %b expected 0", o_cfg_ready); end
    tick();
    checks++;
    if (o_div_cur !== 16'd4 || o_cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg4_idle_apply: div %0d ready %b expected 4 1", o_div_cur, o_cfg_ready);
    end
    i_en = 1;
    n = 0;
    while (o_clk_div !== 1'b1 && n < 20) begin
      tick(); n++;
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL start_n4: got %h expected %h", dut_obs(), mdl_exp()); end
    end
    // Offer 8 in the first high cycle so the transfer is not on a boundary.
    i_cfg_valid = 1; i_cfg_div = 16'd8;
    tick();
    i_cfg_valid = 0;
    checks++;
    if ({o_cfg_ready, o_clk_div} !== 2'b01 || o_div_cur !== 16'd4) begin
      errors++; $display("FAIL cfg8_pending: ready %b clk %b div %0d expected 0 1 4", o_cfg_ready, o_clk_div, o_div_cur);
    end
    n = 0;
    while (o_div_cur !== 16'd8 && n < 10) begin
      tick(); n++;
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL cfg8_wait: got %h expected %h", dut_obs(), mdl_exp()); end
    end
    checks++;
    if (o_div_cur !== 16'd8 || o_clk_div !== 1'b0 || o_cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg8_apply_edge: div %0d clk %b ready %b expected 8 0 1", o_div_cur, o_clk_div, o_cfg_ready);
    end
    n = 1;
    while (o_clk_div === 1'b0 && n < 40) begin
      tick();
      if (o_clk_div === 1'b0) n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL low_len_n8: got %0d expected 4", n); end
    n = 1;
    while (o_clk_div === 1'b1 && n < 40) begin
      tick();
      if (o_clk_div === 1'b1) n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL high_len_n8: got %0d expected 4", n); end
  endtask

  task automatic test_boundary_xfer();
    int n;
    n = 0;
    while (!(m_active && m_pos == m_n - 1) && n < 20) begin
      tick(); n++;
    end
    i_cfg_valid = 1; i_cfg_div = 16'd6;
    tick();
    i_cfg_valid = 0;
    checks++;
    if (o_clk_div !== 1'b0 || o_div_cur !== 16'd8 || o_cfg_ready !== 1'b0) begin
      errors++; $display("FAIL xfer_on_fall: clk %b div %0d ready %b expected 0 8 0", o_clk_div, o_div_cur, o_cfg_ready);
    end
    n = 0;
    while (o_div_cur !== 16'd6 && n < 30) begin
      tick(); n++;
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL xfer_wait: got %h expected %h", dut_obs(), mdl_exp()); end
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL xfer_deferred_period: got %0d expected 8", n); end
  endtask

  task automatic test_illegal_cfg();
    i_cfg_valid = 1; i_cfg_div = 16'd7;
    tick();
    checks++;
    if ({o_cfg_err, o_cfg_ready} !== 2'b11 || o_div_cur !== 16'd6) begin
      errors++; $display("FAIL cfg7_err: err %b ready %b div %0d expected 1 1 6", o_cfg_err, o_cfg_ready, o_div_cur);
    end
    i_cfg_div = 16'd0;
    tick();
    i_cfg_valid = 0;
    checks++;
    if ({o_cfg_err, o_cfg_ready} !== 2'b11 || o_div_cur !== 16'd6) begin
      errors++; $display("FAIL cfg0_err: err %b ready %b div %0d expected 1 1 6", o_cfg_err, o_cfg_ready, o_div_cur);
    end
    tick();
    checks++;
    if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", o_cfg_err); end
    checks++;
    if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL illegal_model: got %h expected %h", dut_obs(), mdl_exp()); end
  endtask

  task automatic test_stop_high();
    int n;
    n = 0;
    while (o_clk_div !== 1'b0 && n < 20) begin tick(); n++; end
    while (o_clk_div !== 1'b1 && n < 40) begin tick(); n++; end
    tick();
    i_en = 0;
    n = 0;
    while (o_clk_div === 1'b1 && n < 20) begin
      n++; tick();
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL stop_high_model: got %h expected %h", dut_obs(), mdl_exp()); end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL stop_high_len: got %0d expected 2", n); end
    checks++;
    if (o_active !== 1'b0) begin errors++; $display("FAIL stop_high_idle: active %b expected 0", o_active); end
  endtask

  task automatic test_stop_low();
    int n;
    i_en = 1;
    n = 0;
    while (o_clk_div !== 1'b1 && n < 20) begin tick(); n++; end
    while (o_clk_div !== 1'b0 && n < 40) begin tick(); n++; end
    i_en = 0;
    tick();
    checks++;
    if (o_active !== 1'b0 || o_clk_div !== 1'b0) begin
      errors++; $display("FAIL stop_low_idle: active %b clk %b expected 0 0", o_active, o_clk_div);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL stop_low_hold: got %h expected %h", dut_obs(), mdl_exp()); end
    end
  endtask

  task automatic test_restart_stopping();
    int n, k;
    i_cfg_valid = 1; i_cfg_div = 16'd10;
    tick();
    i_cfg_valid = 0;
    tick();
    checks++;
    if (o_div_cur !== 16'd10) begin errors++; $display("FAIL cfg10_apply: got %0d expected 10", o_div_cur); end
    i_en = 1;
    n = 0;
    while (o_clk_div !== 1'b1 && n < 20) begin tick(); n++; end
    n = 1; k = 0;
    while (o_clk_div === 1'b1 && k < 40) begin
      i_en = !(k == 1 || k == 2);
      tick(); k++;
      if (o_clk_div === 1'b1) n++;
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL restart_model: got %h expected %h", dut_obs(), mdl_exp()); end
    end
    i_en = 1;
    checks++;
    if (n != 5) begin errors++; $display("FAIL restart_high_len: got %0d expected 5", n); end
    n = 1;
    while (o_clk_div === 1'b0 && n < 40) begin tick(); if (o_clk_div === 1'b0) n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL restart_low_len: got %0d expected 5", n); end
    n = 1;
    while (o_clk_div === 1'b1 && n < 40) begin tick(); if (o_clk_div === 1'b1) n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL restart_next_high: got %0d expected 5", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (o_clk_div !== 1'b1 && n < 20) begin tick(); n++; end
    i_cfg_valid = 1; i_cfg_div = 16'd4;
    tick();
    i_cfg_valid = 0;
    checks++;
    if (o_cfg_ready !== 1'b0 || o_clk_div !== 1'b1) begin
      errors++; $display("FAIL rst_pending: ready %b clk %b expected 0 1", o_cfg_ready, o_clk_div);
    end
    #2 i_rst = 1;
    #1;
    checks++;
    if (o_clk_div !== 1'b0 || o_active !== 1'b0) begin
      errors++; $display("FAIL async_rst: clk %b active %b expected 0 0", o_clk_div, o_active);
    end
    model_reset();
    i_en = 0;
    @(posedge i_clk);
    #3 i_rst = 0;
    #1;
    checks++;
    if (o_div_cur !== 16'd2 || o_cfg_ready !== 1'b1) begin
      errors++; $display("FAIL rst_defaults: div %0d ready %b expected 2 1", o_div_cur, o_cfg_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_exp()) begin errors++; $display("FAIL rst_pending_lost: got %h expected %h", dut_obs(), mdl_exp()); end
    end
  endtask

  task automatic test_random();
    int unsigned r;
    int          shown;
    shown = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) i_en = ~i_en;
      i_cfg_valid = ($urandom_range(7) == 0);
      r = $urandom_range(9);
      if (r < 7)       i_cfg_div = 16'(2 * $urandom_range(6, 1));
      else if (r == 7) i_cfg_div = 16'(2 * $urandom_range(5) + 1);
      else             i_cfg_div = 16'd0;
      tick();
      checks++;
      if (dut_obs() !== mdl_exp()) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cycle %0d: got %h expected %h", i, dut_obs(), mdl_exp());
        end
      end
    end
    i_cfg_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_default_ratio();
    test_ratio_change();
    test_boundary_xfer();
    test_illegal_cfg();
    test_stop_high();
    test_stop_low();
    test_restart_stopping();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
